// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction / resolution unit.
//  - MIPS opcode and REGIMM rt sub-opcode constants for the conditional branches
//  - 2-bit saturating counter encodings and the saturating update helper
//  - FSM state encoding for the BHT sweep-clear controller
package branch_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t CNT_SNT = 2'b00;
    localparam bht_cnt_t CNT_WNT = 2'b01;
    localparam bht_cnt_t CNT_WT  = 2'b10;
    localparam bht_cnt_t CNT_ST  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bht_state_e;

    // Saturating 2-bit counter step: towards ST when taken, towards SNT otherwise.
    function automatic bht_cnt_t cnt_update(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t result;
        result = cnt;
        if (taken) begin
            if (cnt != CNT_ST) result = cnt + 2'b01;
        end else begin
            if (cnt != CNT_SNT) result = cnt - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational MIPS conditional-branch evaluator.
//  op_code, rt : instruction opcode and REGIMM sub-opcode
//  srca, srcb  : rs / rt operands (signed two's complement)
//  cond        : instruction is a recognised conditional branch
//  taken       : branch condition holds (only ever 1 when cond is 1)
//  link        : bltzal/bgezal, independent of the outcome
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      op_code,
    input  logic [4:0]      rt,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            cond,
    output logic            taken,
    output logic            link
);

    logic a_neg;
    logic a_zero;
    logic a_eq_b;

    // Signed comparisons against zero reduce to the sign bit and a zero test.
    assign a_neg  = srca[XLEN-1];
    assign a_zero = (srca == '0);
    assign a_eq_b = (srca == srcb);

    always_comb begin
        cond  = 1'b0;
        taken = 1'b0;
        link  = 1'b0;
        case (op_code)
            OP_BEQ: begin
                cond  = 1'b1;
                taken = a_eq_b;
            end
            OP_BNE: begin
                cond  = 1'b1;
                taken = !a_eq_b;
            end
            OP_BLEZ: begin
                cond  = 1'b1;
                taken = a_neg || a_zero;
            end
            OP_BGTZ: begin
                cond  = 1'b1;
                taken = !a_neg && !a_zero;
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ: begin
                        cond  = 1'b1;
                        taken = a_neg;
                    end
                    RT_BGEZ: begin
                        cond  = 1'b1;
                        taken = !a_neg;
                    end
                    RT_BLTZAL: begin
                        cond  = 1'b1;
                        taken = a_neg;
                        link  = 1'b1;
                    end
                    RT_BGEZAL: begin
                        cond  = 1'b1;
                        taken = !a_neg;
                        link  = 1'b1;
                    end
                    default: begin
                        cond  = 1'b0;
                    end
                endcase
            end
            default: begin
                cond = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch unit: 2-bit saturating-counter BHT predictor plus execute-stage resolver.
//  clk, rst_n          : clock, asynchronous active-low reset
//  pred_pc/pred_taken  : fetch-side lookup (combinational, forced 0 while clearing)
//  res_valid, res_pc, op_code, rt, srca, srcb, res_pred_taken : resolution request
//  is_branch, is_link  : same-cycle resolution results (gated by res_valid)
//  out_valid, out_taken, mispredict : registered resolution results, 1 cycle later
//  bht_clr, busy       : BHT sweep-clear request and in-progress flag
//  branch_cnt, mispred_cnt : saturating statistics counters
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [5:0]       op_code,
    input  logic [4:0]       rt,
    input  logic [XLEN-1:0]  srca,
    input  logic [XLEN-1:0]  srcb,
    input  logic             res_pred_taken,
    output logic             is_branch,
    output logic             is_link,
    output logic             out_valid,
    output logic             out_taken,
    output logic             mispredict,
    input  logic             bht_clr,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bht_cnt_t          bht_reg [BHT_DEPTH];
    bht_state_e        state_reg;
    logic [IDX_W-1:0]  clr_idx_reg;
    logic              busy_reg;
    logic              out_valid_reg;
    logic              out_taken_reg;
    logic              mispredict_reg;
    logic [CNT_W-1:0]  branch_cnt_reg;
    logic [CNT_W-1:0]  mispred_cnt_reg;

    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  res_idx;
    logic              cond;
    logic              taken;
    logic              link;
    logic              resolved_taken;
    logic              mispred_now;
    logic              train_en;
    logic              clr_start;
    logic              clr_last;

    // Word-aligned PCs: the two low bits carry no information for indexing.
    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    branch_cond_eval #(
        .XLEN (XLEN)
    ) u_cond_eval (
        .op_code (op_code),
        .rt      (rt),
        .srca    (srca),
        .srcb    (srcb),
        .cond    (cond),
        .taken   (taken),
        .link    (link)
    );

    assign resolved_taken = res_valid && taken;
    assign mispred_now    = res_valid && (resolved_taken != res_pred_taken);
    assign train_en       = res_valid && cond && (state_reg == ST_IDLE);
    assign clr_start      = (state_reg == ST_IDLE) && bht_clr;
    assign clr_last       = (clr_idx_reg == IDX_W'(BHT_DEPTH - 1));

    // Read-before-write: the lookup sees the stored value, never the pending update.
    assign pred_taken = (state_reg == ST_IDLE) && bht_reg[pred_idx][1];
    assign is_branch  = resolved_taken;
    assign is_link    = res_valid && link;

    assign out_valid   = out_valid_reg;
    assign out_taken   = out_taken_reg;
    assign mispredict  = mispredict_reg;
    assign busy        = busy_reg;
    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;

    // BHT storage: the sweep and training never write in the same cycle because
    // training is only enabled in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_reg[i] <= CNT_WNT;
            end
        end else if (state_reg == ST_CLEAR) begin
            bht_reg[clr_idx_reg] <= CNT_WNT;
        end else if (train_en) begin
            bht_reg[res_idx] <= cnt_update(bht_reg[res_idx], taken);
        end
    end

    // Sweep-clear FSM; a clear request while already clearing is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            clr_idx_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bht_clr) begin
                        state_reg   <= ST_CLEAR;
                        clr_idx_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_idx_reg <= clr_idx_reg + 1'b1;
                    if (clr_last) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Registered resolution results; non-branches report not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_taken_reg  <= 1'b0;
            mispredict_reg <= 1'b0;
        end else begin
            out_valid_reg  <= res_valid;
            out_taken_reg  <= resolved_taken;
            mispredict_reg <= mispred_now;
        end
    end

    // Statistics keep counting during a sweep; only the sweep start zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else if (clr_start) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (res_valid && cond && !(&branch_cnt_reg)) begin
                branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
            end
            if (mispred_now && !(&mispred_cnt_reg)) begin
                mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [5:0]  op_code;
    logic [4:0]  rt;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        res_pred_taken;
    logic        is_branch;
    logic        is_link;
    logic        out_valid;
    logic        out_taken;
    logic        mispredict;
    logic        bht_clr;
    logic        busy;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0]  model_bht [64];
    logic [31:0] model_bc;
    logic [31:0] model_mc;
    logic        in_clear;
    logic [1:0]  exp_q [$];   // {taken, mispredict}

    always #5 clk = ~clk;

    branch_predict_resolve #(
        .XLEN      (32),
        .BHT_DEPTH (64),
        .CNT_W     (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .op_code        (op_code),
        .rt             (rt),
        .srca           (srca),
        .srcb           (srcb),
        .res_pred_taken (res_pred_taken),
        .is_branch      (is_branch),
        .is_link        (is_link),
        .out_valid      (out_valid),
        .out_taken      (out_taken),
        .mispredict     (mispredict),
        .bht_clr        (bht_clr),
        .busy           (busy),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic logic model_pred();
        logic [1:0] e;
        e = model_bht[midx(pred_pc)];
        return in_clear ? 1'b0 : e[1];
    endfunction

    function automatic logic [1:0] model_step(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_bht[i] = 2'b01;
        model_bc = '0;
        model_mc = '0;
        in_clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all_wnt(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (dut.bht_reg[i] !== 2'b01) ok = 1'b0;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // Drive one resolution for a cycle; called at posedge+1, returns at posedge+1.
    task automatic resolve(input string name, input logic [31:0] pc, input logic [5:0] op,
                           input logic [4:0] rtv, input logic [31:0] a, input logic [31:0] b,
                           input logic pred, input logic exp_cond, input logic exp_taken,
                           input logic exp_link);
        logic [1:0] exp_out;
        logic [1:0] got;
        res_pc = pc; op_code = op; rt = rtv; srca = a; srcb = b;
        res_pred_taken = pred; res_valid = 1'b1;
        #1;
        check({name, ".is_branch"}, {31'd0, is_branch}, {31'd0, exp_taken});
        check({name, ".is_link"}, {31'd0, is_link}, {31'd0, exp_link});
        check({name, ".pred_pre"}, {31'd0, pred_taken}, {31'd0, model_pred()});
        exp_q.push_back({exp_taken, exp_taken ^ pred});
        if (exp_cond) model_bc = sat_inc(model_bc);
        if (exp_taken ^ pred) model_mc = sat_inc(model_mc);
        if (exp_cond && !in_clear) model_bht[midx(pc)] = model_step(model_bht[midx(pc)], exp_taken);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        check({name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            exp_out = exp_q.pop_front();
            got = {out_taken, mispredict};
            check({name, ".out_taken_misp"}, {30'd0, got}, {30'd0, exp_out});
        end
        check({name, ".pred_post"}, {31'd0, pred_taken}, {31'd0, model_pred()});
        check({name, ".branch_cnt"}, branch_cnt, model_bc);
        check({name, ".mispred_cnt"}, mispred_cnt, model_mc);
        $display("txn %s pc=%h op=%b rt=%b a=%h b=%h pred=%b -> taken=%b misp=%b bc=%0d mc=%0d",
                 name, pc, op, rtv, a, b, pred, out_taken, mispredict, branch_cnt, mispred_cnt);
    endtask

    initial begin
        int busy_cycles;
        int guard;
        rst_n = 1'b0; pred_pc = 32'h100; res_valid = 1'b0; res_pc = '0;
        op_code = '0; rt = '0; srca = '0; srcb = '0; res_pred_taken = 1'b0; bht_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_taken", {31'd0, out_taken}, 32'd0);
        check("rst.mispredict", {31'd0, mispredict}, 32'd0);
        check("rst.branch_cnt", branch_cnt, 32'd0);
        check("rst.mispred_cnt", mispred_cnt, 32'd0);
        check("rst.pred_taken", {31'd0, pred_taken}, 32'd0);
        check_all_wnt("rst.bht_all_wnt");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: beq taken three times on entry 0, predicted not-taken
        for (int k = 0; k < 3; k++) begin
            resolve("beq_train", 32'h100, 6'b000100, 5'd0, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0);
            check("beq_train.entry", {30'd0, dut.bht_reg[0]}, {30'd0, model_bht[0]});
        end
        check("t1.branch_cnt3", branch_cnt, 32'd3);

        // 2: sign boundaries and bne
        resolve("blez_zero", 32'h204, 6'b000110, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        resolve("bgtz_zero", 32'h208, 6'b000111, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        resolve("bltz_min", 32'h20C, 6'b000001, 5'b00000, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        resolve("bgez_max", 32'h210, 6'b000001, 5'b00001, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        resolve("bne_ne", 32'h214, 6'b000101, 5'd0, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        resolve("bne_eq", 32'h218, 6'b000101, 5'd0, 32'd7, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        resolve("bltzal_neg", 32'h21C, 6'b000001, 5'b10000, 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        resolve("regimm_bad_rt", 32'h220, 6'b000001, 5'b00011, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: link regardless of outcome; non-branch with prediction taken
        resolve("bgezal_neg", 32'h224, 6'b000001, 5'b10001, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        resolve("nonbranch", 32'h100, 6'b000000, 5'd0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("nonbranch.entry0", {30'd0, dut.bht_reg[0]}, 32'd3);

        // 4: train entry 3 to ST, then sweep clear
        pred_pc = 32'hC;
        resolve("train3a", 32'hC, 6'b000100, 5'd0, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        resolve("train3b", 32'hC, 6'b000100, 5'd0, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("train3.entry", {30'd0, dut.bht_reg[3]}, 32'd3);
        bht_clr = 1'b1;
        @(posedge clk);
        #1;
        bht_clr = 1'b0;
        in_clear = 1'b1;
        model_bc = '0;
        model_mc = '0;
        check("clr.entry_busy", {31'd0, busy}, 32'd1);
        check("clr.entry_bc", branch_cnt, 32'd0);
        check("clr.entry_mc", mispred_cnt, 32'd0);
        busy_cycles = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            busy_cycles++;
            guard++;
            if (pred_taken !== 1'b0) check("clr.pred_forced0", {31'd0, pred_taken}, 32'd0);
            if (busy_cycles == 5) bht_clr = 1'b1;   // ignored while clearing
            if (busy_cycles == 20) begin
                bht_clr = 1'b0;
                resolve("train_in_clr", 32'h14, 6'b000100, 5'd0, 32'd2, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        bht_clr = 1'b0;
        in_clear = 1'b0;
        check("clr.busy_cycles", busy_cycles, 32'd64);
        check("clr.entry3", {30'd0, dut.bht_reg[3]}, 32'd1);
        check("clr.entry5", {30'd0, dut.bht_reg[5]}, 32'd1);
        check_all_wnt("clr.bht_all_wnt");
        check("clr.pred_after", {31'd0, pred_taken}, 32'd0);
        check("clr.branch_cnt", branch_cnt, model_bc);

        // 5: same-cycle lookup and training on entry 16
        pred_pc = 32'h40;
        resolve("same_idx", 32'h40, 6'b000100, 5'd0, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        check("same_idx.pred_next", {31'd0, pred_taken}, 32'd1);

        // 6: reset in the middle of a clear sweep
        bht_clr = 1'b1;
        @(posedge clk);
        #1;
        bht_clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.busy", {31'd0, busy}, 32'd0);
        check_all_wnt("rst_mid.bht_all_wnt");
        check("rst_mid.branch_cnt", branch_cnt, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);

        // Saturation of the mispredict counter
        force dut.mispred_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.mispred_cnt_reg;
        model_mc = 32'hFFFF_FFFE;
        resolve("sat_a", 32'h80, 6'b000000, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        resolve("sat_b", 32'h80, 6'b000000, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.mispred_cnt", mispred_cnt, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
